// File: rtl/spi_bootloader.sv
// spi_bootloader: SPI-mode-0 slave that loads and reads back an external RAM
// before handing the RAM over to the host (beeb_*) side.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   booting                 high while the loader owns the RAM
//   progress                one-clk pulse per received SPI byte
//   SCK, SSEL, MOSI, MISO   SPI mode 0 slave, MSB first, SSEL active-low
//   beeb_RAM*               host RAM bus, passed through once booting drops
//   ext_RAM*                external RAM bus
//
// Byte protocol: command (01 write, 02 read, A5 finish), then start and end
// addresses (ADDR_BYTES each, LSB first), then data/dummy bytes. The byte
// after the last data byte returns the 8-bit checksum of the data on MISO.
module spi_bootloader #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned ADDR_BYTES = 3,
    parameter int unsigned WE_CYCLES  = 2,
    parameter int unsigned RD_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              booting,
    output logic              progress,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              beeb_RAMCS_b,
    input  logic              beeb_RAMOE_b,
    input  logic              beeb_RAMWE_b,
    input  logic [ADDR_W-1:0] beeb_RAMA,
    input  logic [7:0]        beeb_RAMDin,
    output logic              ext_RAMCS_b,
    output logic              ext_RAMOE_b,
    output logic              ext_RAMWE_b,
    output logic [ADDR_W-1:0] ext_RAMA,
    output logic [7:0]        ext_RAMDin,
    input  logic [7:0]        ext_RAMDout
);

    localparam int unsigned SRW = 8 * ADDR_BYTES;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CMD       = 4'd1,
        HDR       = 4'd2,
        WAIT_BYTE = 4'd3,
        WRITE     = 4'd4,
        READ      = 4'd5,
        NEXT      = 4'd6,
        CSUM      = 4'd7,
        DISCARD   = 4'd8,
        DONE      = 4'd9
    } state_t;

    // SPI front end
    logic [2:0] sck_q, ssel_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_sr_q;
    logic [7:0] rx_byte_q;
    logic       byte_done_q;
    logic [7:0] miso_sr_q;

    // Loader state
    state_t            state_q, state_d;
    logic              is_read_q, is_read_d;
    logic [7:0]        hdr_cnt_q, hdr_cnt_d;
    logic [SRW-1:0]    sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        cyc_q, cyc_d;
    logic              we_b_q, oe_b_q;

    logic ssel_s, sck_rise, sck_fall, ssel_fall, ssel_rise;

    assign ssel_s    = ssel_q[1];
    assign sck_rise  =  sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] &  sck_q[2];
    assign ssel_fall = ~ssel_q[1] &  ssel_q[2];
    assign ssel_rise =  ssel_q[1] & ~ssel_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_q       <= '0;
            ssel_q      <= '1;
            mosi_q      <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            rx_byte_q   <= '0;
            byte_done_q <= 1'b0;
            miso_sr_q   <= '1;
        end else begin
            sck_q       <= {sck_q[1:0], SCK};
            ssel_q      <= {ssel_q[1:0], SSEL};
            mosi_q      <= {mosi_q[0], MOSI};
            byte_done_q <= 1'b0;
            if (ssel_s) begin
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                rx_sr_q   <= {rx_sr_q[5:0], mosi_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_q   <= {rx_sr_q, mosi_q[1]};
                    byte_done_q <= 1'b1;
                end
            end
            // A falling edge with the bit counter back at 0 follows the 8th
            // rising edge, so that is where the next tx byte is loaded.
            if (ssel_fall) begin
                miso_sr_q <= tx_q;
            end else if (!ssel_s && sck_fall) begin
                miso_sr_q <= (bit_cnt_q == 3'd0) ? tx_q : {miso_sr_q[6:0], 1'b1};
            end
        end
    end

    assign MISO     = ssel_q[2] ? 1'b1 : miso_sr_q[7];
    assign progress = byte_done_q;

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        hdr_cnt_d = hdr_cnt_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        end_d     = end_q;
        data_d    = data_q;
        csum_d    = csum_q;
        tx_d      = tx_q;
        cyc_d     = cyc_q;

        case (state_q)
            IDLE: if (ssel_fall) state_d = CMD;
            CMD: if (byte_done_q) begin
                hdr_cnt_d = '0;
                case (rx_byte_q)
                    8'h01:   begin is_read_d = 1'b0; state_d = HDR; end
                    8'h02:   begin is_read_d = 1'b1; state_d = HDR; end
                    8'hA5:   state_d = DONE;
                    default: state_d = DISCARD;
                endcase
            end
            HDR: if (byte_done_q) begin
                // Bytes arrive LSB first: shift in from the top so the field
                // ends up right-aligned after ADDR_BYTES bytes.
                sr_d      = SRW'({rx_byte_q, sr_q} >> 8);
                hdr_cnt_d = hdr_cnt_q + 8'd1;
                if (hdr_cnt_q == 8'(ADDR_BYTES - 1)) addr_d = ADDR_W'(sr_d);
                if (hdr_cnt_q == 8'(2 * ADDR_BYTES - 1)) begin
                    end_d   = ADDR_W'(sr_d);
                    csum_d  = '0;
                    cyc_d   = '0;
                    state_d = is_read_q ? READ : WAIT_BYTE;
                end
            end
            WAIT_BYTE: if (byte_done_q) begin
                cyc_d = '0;
                if (is_read_q) begin
                    state_d = NEXT;
                end else begin
                    data_d  = rx_byte_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cyc_d = cyc_q + 8'd1;
                if (cyc_q == 8'(WE_CYCLES - 1)) state_d = NEXT;
            end
            READ: begin
                cyc_d = cyc_q + 8'd1;
                if (cyc_q == 8'(RD_CYCLES - 1)) begin
                    data_d  = ext_RAMDout;
                    tx_d    = ext_RAMDout;
                    state_d = WAIT_BYTE;
                end
            end
            NEXT: begin
                csum_d = csum_q + data_q;
                cyc_d  = '0;
                if (addr_q == end_q) begin
                    state_d = CSUM;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = is_read_q ? READ : WAIT_BYTE;
                end
            end
            CSUM: begin
                tx_d    = csum_q;
                state_d = DISCARD;
            end
            DISCARD: if (ssel_s) state_d = IDLE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (ssel_rise && state_q != DONE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            is_read_q <= 1'b0;
            hdr_cnt_q <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            end_q     <= '0;
            data_q    <= '0;
            csum_q    <= '0;
            tx_q      <= 8'hFF;
            cyc_q     <= '0;
            we_b_q    <= 1'b1;
            oe_b_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            hdr_cnt_q <= hdr_cnt_d;
            sr_q      <= sr_d;
            addr_q    <= addr_d;
            end_q     <= end_d;
            data_q    <= data_d;
            csum_q    <= csum_d;
            tx_q      <= tx_d;
            cyc_q     <= cyc_d;
            // Registered strobes: low exactly while state_q is WRITE/READ.
            we_b_q    <= (state_d != WRITE);
            oe_b_q    <= (state_d != READ);
        end
    end

    assign booting     = (state_q != DONE);
    assign ext_RAMCS_b = booting ? 1'b0   : beeb_RAMCS_b;
    assign ext_RAMOE_b = booting ? oe_b_q : beeb_RAMOE_b;
    assign ext_RAMWE_b = booting ? we_b_q : beeb_RAMWE_b;
    assign ext_RAMA    = booting ? addr_q : beeb_RAMA;
    assign ext_RAMDin  = booting ? data_q : beeb_RAMDin;

endmodule

// File: tb/tb_spi_bootloader.sv
module tb_spi_bootloader;

    localparam int HALF = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        booting, progress;
    logic        SCK, SSEL, MOSI, MISO;
    logic        beeb_RAMCS_b, beeb_RAMOE_b, beeb_RAMWE_b;
    logic [17:0] beeb_RAMA;
    logic [7:0]  beeb_RAMDin;
    logic        ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b;
    logic [17:0] ext_RAMA;
    logic [7:0]  ext_RAMDin, ext_RAMDout;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] mem [0:262143];

    spi_bootloader #(.ADDR_W(18), .ADDR_BYTES(3), .WE_CYCLES(2), .RD_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .booting(booting), .progress(progress),
        .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
        .beeb_RAMCS_b(beeb_RAMCS_b), .beeb_RAMOE_b(beeb_RAMOE_b), .beeb_RAMWE_b(beeb_RAMWE_b),
        .beeb_RAMA(beeb_RAMA), .beeb_RAMDin(beeb_RAMDin),
        .ext_RAMCS_b(ext_RAMCS_b), .ext_RAMOE_b(ext_RAMOE_b), .ext_RAMWE_b(ext_RAMWE_b),
        .ext_RAMA(ext_RAMA), .ext_RAMDin(ext_RAMDin), .ext_RAMDout(ext_RAMDout)
    );

    always #5 clk = ~clk;

    assign ext_RAMDout = mem[ext_RAMA];

    // RAM model and write log, sampled on the falling clock edge
    int          we_run   = 0;
    int          oe_lows  = 0;
    int          prog_cnt = 0;
    logic [17:0] cur_a;
    logic [7:0]  cur_d;
    logic [17:0] w_addr[$];
    logic [7:0]  w_data[$];
    int          w_len[$];

    always @(negedge clk) begin
        if (booting && !ext_RAMCS_b && !ext_RAMWE_b) begin
            we_run++;
            cur_a = ext_RAMA;
            cur_d = ext_RAMDin;
            mem[ext_RAMA] = ext_RAMDin;
        end else if (we_run > 0) begin
            w_addr.push_back(cur_a);
            w_data.push_back(cur_d);
            w_len.push_back(we_run);
            we_run = 0;
        end
        if (booting && !ext_RAMCS_b && !ext_RAMOE_b) oe_lows++;
    end

    always @(posedge clk) if (progress) prog_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input bit stop_at_last_rise, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            clks(HALF);
            SCK   = 1'b1;
            rx[i] = MISO;
            if (!(stop_at_last_rise && i == 0)) begin
                clks(HALF);
                SCK = 1'b0;
            end
        end
    endtask

    task automatic xfer(input logic [7:0] tx[$], input bit raise, output logic [7:0] rx[$]);
        logic [7:0] r;
        rx = {};
        SSEL = 1'b0;
        clks(HALF);
        foreach (tx[i]) begin
            spi_byte(tx[i], 1'b0, r);
            rx.push_back(r);
        end
        clks(HALF);
        if (raise) begin
            SSEL = 1'b1;
            clks(2 * HALF);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] r[$];
        logic [7:0] b;
        int         base, p0, o0;
        bit         found;

        reset_n      = 1'b0;
        SCK          = 1'b0;
        SSEL         = 1'b1;
        MOSI         = 1'b0;
        beeb_RAMCS_b = 1'b1;
        beeb_RAMOE_b = 1'b1;
        beeb_RAMWE_b = 1'b1;
        beeb_RAMA    = 18'h01234;
        beeb_RAMDin  = 8'h5A;
        clks(4);
        reset_n = 1'b1;
        clks(4);

        check("rst_booting", booting, 1);
        check("rst_we", ext_RAMWE_b, 1);
        check("rst_oe", ext_RAMOE_b, 1);
        check("rst_cs", ext_RAMCS_b, 0);
        check("rst_miso", MISO, 1);
        check("rst_progress", progress, 0);
        check("rst_state", 32'(dut.state_q), 0);
        check("rst_addr", ext_RAMA, 0);
        check("rst_din", ext_RAMDin, 0);

        // Write AA/BB/CC to 10h..12h, checksum 0x31 on the following byte
        base = w_addr.size();
        p0   = prog_cnt;
        q = {8'h01, 8'h10, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        xfer(q, 1'b1, r);
        check("wr_count", w_addr.size() - base, 3);
        if (w_addr.size() >= base + 3) begin
            check("wr0_addr", w_addr[base], 18'h10);
            check("wr0_data", w_data[base], 8'hAA);
            check("wr0_len", w_len[base], 2);
            check("wr1_addr", w_addr[base+1], 18'h11);
            check("wr1_data", w_data[base+1], 8'hBB);
            check("wr1_len", w_len[base+1], 2);
            check("wr2_addr", w_addr[base+2], 18'h12);
            check("wr2_data", w_data[base+2], 8'hCC);
            check("wr2_len", w_len[base+2], 2);
        end
        check("wr_csum", r[10], 8'h31);
        check("wr_progress", prog_cnt - p0, 11);
        check("wr_state_idle", 32'(dut.state_q), 0);

        // Read back 10h..11h, checksum 0x65
        base = w_addr.size();
        o0   = oe_lows;
        q = {8'h02, 8'h10, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        xfer(q, 1'b1, r);
        check("rd_byte0", r[7], 8'hAA);
        check("rd_byte1", r[8], 8'hBB);
        check("rd_csum", r[9], 8'h65);
        check("rd_nowrite", w_addr.size() - base, 0);
        check("rd_oe_len", oe_lows - o0, 4);

        // Abort after one of three data bytes, then a fresh write
        base = w_addr.size();
        q = {8'h01, 8'h20, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h11};
        xfer(q, 1'b1, r);
        check("ab_count", w_addr.size() - base, 1);
        if (w_addr.size() >= base + 1) begin
            check("ab_addr", w_addr[base], 18'h20);
            check("ab_data", w_data[base], 8'h11);
        end
        check("ab_state", 32'(dut.state_q), 0);
        check("ab_booting", booting, 1);
        check("ab_we", ext_RAMWE_b, 1);
        base = w_addr.size();
        q = {8'h01, 8'h30, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h5A, 8'h00};
        xfer(q, 1'b1, r);
        check("ab2_count", w_addr.size() - base, 1);
        if (w_addr.size() >= base + 1) check("ab2_addr", w_addr[base], 18'h30);
        check("ab2_csum", r[8], 8'h5A);

        // Wrap: start FFFFFF truncates to 3FFFF, end 1
        base = w_addr.size();
        q = {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        xfer(q, 1'b1, r);
        check("wrap_count", w_addr.size() - base, 3);
        if (w_addr.size() >= base + 3) begin
            check("wrap0_addr", w_addr[base], 18'h3FFFF);
            check("wrap1_addr", w_addr[base+1], 18'h00000);
            check("wrap2_addr", w_addr[base+2], 18'h00001);
            check("wrap2_data", w_data[base+2], 8'h03);
        end
        check("wrap_csum", r[10], 8'h06);

        // Unknown command: no RAM activity
        base = w_addr.size();
        o0   = oe_lows;
        q = {8'h7E, 8'h55, 8'h66};
        xfer(q, 1'b1, r);
        check("bad_nowrite", w_addr.size() - base, 0);
        check("bad_noread", oe_lows - o0, 0);
        check("bad_state", 32'(dut.state_q), 0);

        // Reset pulsed while WE is low
        base = w_addr.size();
        q = {8'h01, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        xfer(q, 1'b0, r);
        spi_byte(8'h77, 1'b1, b);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            clks(1);
            if (!ext_RAMWE_b) found = 1'b1;
        end
        check("rst_wait_we", found, 1);
        reset_n = 1'b0;
        #1;
        check("rst_we_async", ext_RAMWE_b, 1);
        SCK  = 1'b0;
        SSEL = 1'b1;
        clks(4);
        reset_n = 1'b1;
        clks(2 * HALF);
        check("rst2_nowrite", w_addr.size() - base, 0);
        check("rst2_we", ext_RAMWE_b, 1);
        check("rst2_state", 32'(dut.state_q), 0);
        check("rst2_booting", booting, 1);
        check("rst2_miso", MISO, 1);

        // Finish: RAM handed to the host bus
        q = {8'hA5};
        xfer(q, 1'b1, r);
        check("fin_booting", booting, 0);
        check("fin_state", 32'(dut.state_q), 9);
        check("fin_rama", ext_RAMA, 18'h01234);
        beeb_RAMA    = 18'h2ABCD;
        beeb_RAMDin  = 8'hC3;
        beeb_RAMWE_b = 1'b0;
        beeb_RAMCS_b = 1'b1;
        #1;
        check("fin_rama2", ext_RAMA, 18'h2ABCD);
        check("fin_din", ext_RAMDin, 8'hC3);
        check("fin_we", ext_RAMWE_b, 0);
        check("fin_cs", ext_RAMCS_b, 1);
        beeb_RAMWE_b = 1'b1;
        q = {8'h01, 8'h10, 8'h00, 8'h00};
        xfer(q, 1'b1, r);
        check("fin_ignore", booting, 0);
        check("fin_ignore_state", 32'(dut.state_q), 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
